// File: rtl/ad9653_bitslip_align.sv
// Word-alignment trainer for the AD9653 LVDS capture path (clk_div domain).
// While the ADC emits a fixed test pattern, each lane is trained in turn:
// wait for the data to settle, compare against the pattern, request a bitslip
// on mismatch, and accept the lane after MATCH_CNT consecutive matches.
module ad9653_bitslip_align #(
    parameter int DWIDTH    = 8,
    parameter int SETTLE    = 16,
    parameter int MATCH_CNT = 8,
    parameter int PULSE_LEN = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            pattern,
    input  logic [8*DWIDTH-1:0]   dout,
    output logic [DWIDTH-1:0]     bitslip,
    output logic                  busy,
    output logic                  done,
    output logic [DWIDTH-1:0]     lane_ok,
    output logic [3*DWIDTH-1:0]   slip_cnt
);

    localparam int LW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int MW = $clog2(MATCH_CNT + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_PULSE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 state, state_n;
    logic [LW-1:0]          lane, lane_n;
    logic [SW-1:0]          settle_cnt, settle_n;
    logic [MW-1:0]          match_cnt, match_n;
    logic [PW-1:0]          pulse_cnt, pulse_n;
    logic [DWIDTH-1:0]      lane_ok_n, bitslip_n;
    logic [3*DWIDTH-1:0]    slip_n;
    logic                   busy_n, done_n;
    logic [7:0]             lane_word;
    logic [2:0]             cur_slip;

    // Next-state and next-output logic; every output is registered below, so
    // the outputs are derived from the state being entered.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave
        // it unassigned, which would otherwise infer a latch.
        state_n   = state;
        lane_n    = lane;
        settle_n  = settle_cnt;
        match_n   = match_cnt;
        pulse_n   = pulse_cnt;
        lane_ok_n = lane_ok;
        slip_n    = slip_cnt;
        lane_word = dout[8*lane +: 8];
        cur_slip  = slip_cnt[3*lane +: 3];

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lane_ok_n = '0;
                    slip_n    = '0;
                    lane_n    = '0;
                    settle_n  = '0;
                    state_n   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    settle_n = '0;
                    match_n  = '0;
                    state_n  = S_CHECK;
                end else begin
                    settle_n = settle_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (lane_word == pattern) begin
                    if (match_cnt == MW'(MATCH_CNT - 1)) begin
                        lane_ok_n[lane] = 1'b1;
                        state_n         = S_NEXT;
                    end else begin
                        match_n = match_cnt + 1'b1;
                    end
                end else if (cur_slip != 3'd7) begin
                    slip_n[3*lane +: 3] = cur_slip + 3'd1;
                    pulse_n             = '0;
                    state_n             = S_PULSE;
                end else begin
                    // Every boundary position tried: the lane is reported as failed.
                    state_n = S_NEXT;
                end
            end
            S_PULSE: begin
                if (pulse_cnt == PW'(PULSE_LEN - 1)) begin
                    settle_n = '0;
                    state_n  = S_SETTLE;
                end else begin
                    pulse_n = pulse_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                if (lane == LW'(DWIDTH - 1)) begin
                    state_n = S_DONE;
                end else begin
                    lane_n   = lane + 1'b1;
                    settle_n = '0;
                    state_n  = S_SETTLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        bitslip_n = '0;
        if (state_n == S_PULSE) bitslip_n[lane_n] = 1'b1;
        busy_n = (state_n == S_SETTLE) || (state_n == S_CHECK) ||
                 (state_n == S_PULSE)  || (state_n == S_NEXT);
        done_n = (state_n == S_DONE);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lane       <= '0;
            settle_cnt <= '0;
            match_cnt  <= '0;
            pulse_cnt  <= '0;
            lane_ok    <= '0;
            slip_cnt   <= '0;
            bitslip    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state      <= state_n;
            lane       <= lane_n;
            settle_cnt <= settle_n;
            match_cnt  <= match_n;
            pulse_cnt  <= pulse_n;
            lane_ok    <= lane_ok_n;
            slip_cnt   <= slip_n;
            bitslip    <= bitslip_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_ad9653_bitslip_align.sv
// Directed bench for ad9653_bitslip_align at default parameters. A small lane
// model drives dout (pattern, rotated lane, stuck lane, one-word glitch) and a
// monitor counts bitslip pulses; expected cycles and results are hand-derived.
module tb_ad9653_bitslip_align;

    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        pattern = 8'hA1;
    logic [8*DW-1:0]   dout;
    logic [DW-1:0]     bitslip;
    logic              busy;
    logic              done;
    logic [DW-1:0]     lane_ok;
    logic [3*DW-1:0]   slip_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Lane model controls.
    bit rot3 = 1'b0, zero5 = 1'b0, zero2 = 1'b0, glitch0 = 1'b0;
    int rot_base = 0;
    int cyc = 0;

    // Bitslip monitor state.
    int rises[DW];
    int hi[DW];
    logic [DW-1:0] prev_bs = '0;
    bit multi_hot = 1'b0;

    ad9653_bitslip_align dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pattern  (pattern),
        .dout     (dout),
        .bitslip  (bitslip),
        .busy     (busy),
        .done     (done),
        .lane_ok  (lane_ok),
        .slip_cnt (slip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] p, input logic [2:0] k);
        logic [15:0] w;
        w = {p, p} << k;
        return w[15:8];
    endfunction

    // Cycle index relative to the edge that sampled start (edge 0).
    always @(posedge clk) cyc <= start ? 1 : cyc + 1;

    // Count rising edges and high cycles of each bitslip bit.
    always @(posedge clk) begin
        prev_bs <= bitslip;
        if ($countones(bitslip) > 1) multi_hot <= 1'b1;
        for (int i = 0; i < DW; i++) begin
            if (bitslip[i] && !prev_bs[i]) rises[i] <= rises[i] + 1;
            if (bitslip[i]) hi[i] <= hi[i] + 1;
        end
    end

    // Lane model: lane 3 rotates one bit per bitslip rising edge.
    always_comb begin
        for (int i = 0; i < DW; i++) begin
            dout[8*i +: 8] = pattern;
        end
        if (rot3)    dout[31:24] = rotl(pattern, 3'(5 + rises[3] - rot_base));
        if (zero5)   dout[47:40] = 8'h00;
        if (zero2)   dout[23:16] = 8'h00;
        if (glitch0 && cyc == 24) dout[7:0] = 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a training run, check the cycle-1 state, and wait (bounded) for done.
    task automatic train(input string tag, input int exp_done, input int busy_start);
        int done_at;
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " c1 busy"}, 32'(busy), 32'd1);
        check({tag, " c1 done"}, 32'(done), 32'd0);
        check({tag, " c1 lane_ok"}, 32'(lane_ok), 32'd0);
        check({tag, " c1 slip_cnt"}, 32'(slip_cnt), 32'd0);
        for (int e = 1; e < 4000; e++) begin
            @(posedge clk);
            #1;
            start = (e == busy_start);
            if (done) begin
                done_at = e + 1;
                break;
            end
        end
        start = 1'b0;
        check({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    int r0[DW];
    int h0[DW];
    int other;

    initial begin
        // Reset state.
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst bitslip", 32'(bitslip), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst lane_ok", 32'(lane_ok), 32'd0);
        check("rst slip_cnt", 32'(slip_cnt), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // All lanes correct.
        r0 = rises;
        train("aligned", 201, -1);
        other = 0;
        for (int i = 0; i < DW; i++) other += rises[i] - r0[i];
        check("aligned pulses", 32'(other), 32'd0);
        check("aligned lane_ok", 32'(lane_ok), 32'hFF);
        check("aligned slip_cnt", 32'(slip_cnt), 32'd0);
        check("aligned done", 32'(done), 32'd1);

        // Lane 3 starts five rotations off: three slips of 19 cycles each.
        rot_base = rises[3];
        rot3 = 1'b1;
        r0 = rises;
        h0 = hi;
        train("rot3", 258, -1);
        other = 0;
        for (int i = 0; i < DW; i++) if (i != 3) other += rises[i] - r0[i];
        check("rot3 pulses", 32'(rises[3] - r0[3]), 32'd3);
        check("rot3 high_cycles", 32'(hi[3] - h0[3]), 32'd6);
        check("rot3 other_pulses", 32'(other), 32'd0);
        check("rot3 slip_cnt", 32'(slip_cnt), 32'h000600);
        check("rot3 lane_ok", 32'(lane_ok), 32'hFF);
        rot3 = 1'b0;

        // Lane 5 stuck at 0x00: seven slips, then the lane fails.
        zero5 = 1'b1;
        r0 = rises;
        h0 = hi;
        train("zero5", 327, -1);
        check("zero5 pulses", 32'(rises[5] - r0[5]), 32'd7);
        check("zero5 high_cycles", 32'(hi[5] - h0[5]), 32'd14);
        check("zero5 slip_cnt", 32'(slip_cnt), 32'h038000);
        check("zero5 lane_ok", 32'(lane_ok), 32'hDF);
        check("zero5 done", 32'(done), 32'd1);
        zero5 = 1'b0;

        // Lane 0: seven matches, one bad word, then correct; match count restarts.
        glitch0 = 1'b1;
        r0 = rises;
        train("glitch0", 227, -1);
        check("glitch0 pulses", 32'(rises[0] - r0[0]), 32'd1);
        check("glitch0 slip_cnt", 32'(slip_cnt), 32'd1);
        check("glitch0 lane_ok", 32'(lane_ok), 32'hFF);
        glitch0 = 1'b0;

        // Start pulsed mid-training is ignored (run also starts from DONE).
        train("busy_start", 201, 50);
        check("busy_start lane_ok", 32'(lane_ok), 32'hFF);
        check("busy_start slip_cnt", 32'(slip_cnt), 32'd0);

        // Reset asserted while bitslip[2] is high.
        zero2 = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 0; e < 2000; e++) begin
            if (bitslip[2]) break;
            @(posedge clk);
            #1;
        end
        check("rst_mid bitslip2_seen", 32'(bitslip[2]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid bitslip", 32'(bitslip), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid lane_ok", 32'(lane_ok), 32'd0);
        check("rst_mid slip_cnt", 32'(slip_cnt), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        zero2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid idle busy", 32'(busy), 32'd0);
        check("rst_mid idle bitslip", 32'(bitslip), 32'd0);
        train("retrain", 201, -1);
        check("retrain lane_ok", 32'(lane_ok), 32'hFF);
        check("retrain slip_cnt", 32'(slip_cnt), 32'd0);

        check("bitslip one_hot", 32'(multi_hot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9653_bitslip_align.md
# ad9653_bitslip_align

Word-alignment trainer that sits directly downstream of the AD9653 LVDS capture block, in its `clk_div` domain. While the ADC outputs a fixed test pattern, it consumes the per-lane deserialized bytes and finds the correct word boundary on each lane in turn. It issues `bitslip` requests back into the capture block, then requires a run of consecutive pattern matches before declaring the lane aligned. It reports per-lane pass/fail and slip counts to the control/register layer.

## Interface
Parameters:
- `DWIDTH`, 8: number of LVDS data lanes; matches the capture block lane count.
- `SETTLE`, 16: cycles waited after start or after each bitslip before comparing data.
- `MATCH_CNT`, 8: consecutive matching words required to pass a lane (≥1).
- `PULSE_LEN`, 2: cycles each bitslip request is held high (≥1).

Ports:
- `clk`  in  1: `clk_div` of the capture block; only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level-sampled; starts training when idle.
- `pattern`  in  8: expected byte per lane; held stable during training.
- `dout`  in  8*DWIDTH: captured bytes; lane i is `dout[8i+7:8i]`.
- `bitslip`  out  DWIDTH: bitslip request per lane, to capture block (edge-detected there).
- `busy`  out  1: training in progress.
- `done`  out  1: training finished; sticky until next accepted start or reset.
- `lane_ok`  out  DWIDTH: lane i aligned.
- `slip_cnt`  out  3*DWIDTH: bitslips applied to lane i, `slip_cnt[3i+2:3i]`.

## Operation
- Reset (async assert, sync release): state IDLE; all outputs 0; lane index 0; all counters 0.
- States: IDLE, SETTLE, CHECK, PULSE, NEXT, DONE.
- IDLE or DONE with `start`=1: clear `lane_ok`, `slip_cnt` and `done`; set lane=0 and `busy`=1; go to SETTLE.
- `start` while busy is ignored.
- SETTLE: count SETTLE cycles, then go to CHECK with the match counter at 0. `dout` is ignored here.
- CHECK, each cycle, compare `dout[lane]` with `pattern`:
  - Match: increment the match counter. On reaching MATCH_CNT, set `lane_ok[lane]`=1 and go to NEXT.
  - Mismatch with `slip_cnt[lane]` < 7: increment `slip_cnt[lane]` and go to PULSE.
  - Mismatch with `slip_cnt[lane]` = 7: the lane fails. `lane_ok[lane]` stays 0 and the FSM goes to NEXT.
- PULSE: drive `bitslip[lane]`=1 for PULSE_LEN cycles, then go to SETTLE. All other `bitslip` bits stay 0. `bitslip` is fully 0 in every other state.
- NEXT (1 cycle): if lane = DWIDTH−1, go to DONE with `done`=1 and `busy`=0. Otherwise increment lane and go to SETTLE.
- DONE: hold results; behaves as IDLE for `start`.
- Only one lane is ever in training; the results of other lanes are untouched.
- `slip_cnt` saturates by construction at 7; at most 8 boundary positions are tried per lane.

## Timing
- All outputs are registered.
- Cycle 0 is the edge that samples `start`=1.
- From cycle 1: `busy`=1, and `done`, `lane_ok` and `slip_cnt` are all 0.
- A lane with no slips costs SETTLE + MATCH_CNT + 1 cycles.
  - With all lanes aligned at start: `done`=1 and `busy`=0 from cycle 1 + DWIDTH·(SETTLE+MATCH_CNT+1), which is 201 at defaults.
- Each slip adds PULSE_LEN + SETTLE cycles, plus the CHECK cycles consumed up to and including the mismatching word.
- `bitslip` rises on the cycle after the mismatch is sampled. Its falling edge is PULSE_LEN cycles later.
- `lane_ok[lane]` sets on the cycle after the MATCH_CNT-th consecutive match is sampled.
- Reset asserted mid-training clears `bitslip` immediately, so no partial pulse continues. After release the block is in IDLE.

## Test plan
- All lanes correct, `pattern`=0xA1, defaults:
  - No `bitslip` pulses.
  - `lane_ok`=0xFF, `slip_cnt` all 0.
  - `done` rises at cycle 201.
- Bench model rotates lane 3 by one bit per `bitslip` rising edge, starting 5 rotations off:
  - Exactly 3 two-cycle pulses on `bitslip[3]`, none on other lanes.
  - `slip_cnt[11:9]`=3, `lane_ok`=0xFF.
- Lane 5 driven constant 0x00 with `pattern`=0xA1:
  - Exactly 7 pulses on `bitslip[5]`.
  - `slip_cnt[17:15]`=7, `lane_ok`=0xDF, `done`=1.
- Lane 0 matches for 7 cycles, then one mismatch, then always correct:
  - One slip issued, the match counter restarts, final `lane_ok[0]`=1.
- `start` pulsed again while busy: no effect on timing or results.
- `start` after `done`: results clear on cycle 1 and retraining proceeds.
- `reset_n` asserted while `bitslip[2]` is high:
  - All outputs 0 asynchronously.
  - After release, `start` gives a full, correct retraining.
